// File: rtl/pipe_skid_reg_pkg.sv
// Shared definitions for the pipeline skid-register family: occupancy states,
// the default bubble word and the payload widths of each pipeline boundary.
package pipe_skid_reg_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_ONE   = 2'b01,
        ST_FULL  = 2'b10
    } skid_state_e;

    localparam int IF_ID_W  = 96;
    localparam int ID_EX_W  = 192;
    localparam int EX_MEM_W = 136;
    localparam int MEM_WB_W = 104;

    // Widest boundary; narrower instances take the low bits.
    localparam logic [ID_EX_W-1:0] NOP_DEFAULT = {ID_EX_W{1'b0}};

endpackage

// File: rtl/pipe_slot.sv
// One payload slot: loads a new word, clears to the bubble value, or holds.
// Clear wins over load so a discarded entry never lands in the slot.
module pipe_slot
    import pipe_skid_reg_pkg::*;
#(
    parameter int               WIDTH   = IF_ID_W,
    parameter logic [WIDTH-1:0] NOP_VAL = WIDTH'(NOP_DEFAULT)
) (
    input  logic             clk_i,
    input  logic             clr_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] data_q;

    // Slot storage, updated on the falling edge like the rest of the pipeline.
    always_ff @(negedge clk_i) begin
        if (clr_i) begin
            data_q <= NOP_VAL;
        end else if (load_i) begin
            data_q <= d_i;
        end else begin
            data_q <= data_q;
        end
    end

    assign q_o = data_q;

endmodule

// File: rtl/pipe_skid_reg.sv
// Two-entry skid buffer between pipeline stages: MAIN presents the head entry,
// SKID absorbs one extra word so in_ready can come straight from a register.
module pipe_skid_reg
    import pipe_skid_reg_pkg::*;
#(
    parameter int               WIDTH   = IF_ID_W,
    parameter logic [WIDTH-1:0] NOP_VAL = WIDTH'(NOP_DEFAULT),
    parameter int               CNT_W   = 16
) (
    input  logic             Clk,
    input  logic             Clr,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    skid_state_e      state_q, state_d;
    logic             in_ready_q;
    logic             out_valid_q;
    logic [CNT_W-1:0] stall_cnt_q;

    logic             accept_s;
    logic             pop_s;
    logic             main_load_s;
    logic             main_clr_s;
    logic             main_from_skid_s;
    logic             skid_load_s;
    logic             skid_clr_s;
    logic [WIDTH-1:0] main_d_s;
    logic [WIDTH-1:0] main_q_s;
    logic [WIDTH-1:0] skid_q_s;

    assign accept_s = in_valid & in_ready_q;
    assign pop_s    = out_valid_q & out_ready;
    assign main_d_s = main_from_skid_s ? skid_q_s : in_data;

    // Next-state and slot-control decode; Clr and flush both empty the buffer.
    always_comb begin
        state_d          = state_q;
        main_load_s      = 1'b0;
        main_clr_s       = 1'b0;
        main_from_skid_s = 1'b0;
        skid_load_s      = 1'b0;
        skid_clr_s       = 1'b0;
        if (Clr || flush) begin
            state_d    = ST_EMPTY;
            main_clr_s = 1'b1;
            skid_clr_s = 1'b1;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (accept_s) begin
                        state_d     = ST_ONE;
                        main_load_s = 1'b1;
                    end else begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_ONE: begin
                    if (accept_s && pop_s) begin
                        main_load_s = 1'b1;
                    end else if (accept_s) begin
                        state_d     = ST_FULL;
                        skid_load_s = 1'b1;
                    end else if (pop_s) begin
                        state_d    = ST_EMPTY;
                        main_clr_s = 1'b1;
                    end else begin
                        state_d = ST_ONE;
                    end
                end
                ST_FULL: begin
                    if (pop_s) begin
                        state_d          = ST_ONE;
                        main_load_s      = 1'b1;
                        main_from_skid_s = 1'b1;
                        skid_clr_s       = 1'b1;
                    end else begin
                        state_d = ST_FULL;
                    end
                end
                default: begin
                    state_d    = ST_EMPTY;
                    main_clr_s = 1'b1;
                    skid_clr_s = 1'b1;
                end
            endcase
        end
    end

    // State plus handshake flags, registered from the next state so neither
    // in_ready nor out_valid has a combinational path from out_ready.
    always_ff @(negedge Clk) begin
        if (Clr) begin
            state_q     <= ST_EMPTY;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= (state_d != ST_FULL);
            out_valid_q <= (state_d != ST_EMPTY);
        end
    end

    // Saturating stall counter; flush deliberately leaves it alone.
    always_ff @(negedge Clk) begin
        if (Clr) begin
            stall_cnt_q <= {CNT_W{1'b0}};
        end else if (out_valid_q && !out_ready && (stall_cnt_q != CNT_MAX)) begin
            stall_cnt_q <= stall_cnt_q + CNT_W'(1);
        end else begin
            stall_cnt_q <= stall_cnt_q;
        end
    end

    pipe_slot #(
        .WIDTH   (WIDTH),
        .NOP_VAL (NOP_VAL)
    ) u_main (
        .clk_i  (Clk),
        .clr_i  (main_clr_s),
        .load_i (main_load_s),
        .d_i    (main_d_s),
        .q_o    (main_q_s)
    );

    pipe_slot #(
        .WIDTH   (WIDTH),
        .NOP_VAL (NOP_VAL)
    ) u_skid (
        .clk_i  (Clk),
        .clr_i  (skid_clr_s),
        .load_i (skid_load_s),
        .d_i    (in_data),
        .q_o    (skid_q_s)
    );

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = main_q_s;
    assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Bench for pipe_skid_reg: directed vector table, saturation run and random
// traffic, all checked against a queue-based model of a two-deep FIFO.
module tb_pipe_skid_reg;

    localparam int W = 32;
    localparam int CW = 16;

    logic          Clk = 1'b0;
    logic          Clr = 1'b0;
    logic          flush = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [W-1:0]  in_data = 32'h0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [W-1:0]  out_data;
    logic [CW-1:0] stall_cnt;

    int n_chk = 0;
    int n_fail = 0;

    logic [W-1:0] mq[$];
    int           m_cnt = 0;

    typedef struct {
        logic         c;
        logic         f;
        logic         iv;
        logic [W-1:0] d;
        logic         ordy;
        logic         ev;
        logic [W-1:0] ed;
        logic         er;
        int           ecnt;
    } vec_t;

    vec_t vq[$];

    always #5 Clk = ~Clk;

    pipe_skid_reg #(
        .WIDTH   (W),
        .NOP_VAL (32'h0),
        .CNT_W   (CW)
    ) dut (
        .Clk       (Clk),
        .Clr       (Clr),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .stall_cnt (stall_cnt)
    );

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_model(input string tag);
        chk({tag, " valid"}, 32'(out_valid), 32'(mq.size() > 0));
        chk({tag, " data"}, out_data, (mq.size() > 0) ? mq[0] : 32'h0);
        chk({tag, " ready"}, 32'(in_ready), 32'(mq.size() < 2));
        chk({tag, " stall"}, 32'(stall_cnt), 32'(m_cnt));
    endtask

    // One falling-edge cycle: drive, advance the model, optionally compare.
    task automatic cycle(input logic c, input logic f, input logic iv,
                         input logic [W-1:0] d, input logic ordy, input bit do_chk);
        bit acc;
        bit pop;
        Clr = c; flush = f; in_valid = iv; in_data = d; out_ready = ordy;
        acc = iv && (mq.size() < 2);
        pop = (mq.size() > 0) && ordy;
        @(negedge Clk);
        #1;
        if (c) begin
            mq.delete();
            m_cnt = 0;
        end else begin
            if ((mq.size() > 0) && !ordy && (m_cnt < 65535)) m_cnt++;
            if (f) begin
                mq.delete();
            end else begin
                if (pop) mq.delete(0);
                if (acc) mq.push_back(d);
            end
        end
        if (do_chk) check_model("model");
    endtask

    task automatic add(input logic c, input logic f, input logic iv, input logic [W-1:0] d,
                       input logic ordy, input logic ev, input logic [W-1:0] ed,
                       input logic er, input int ecnt);
        vec_t v;
        v.c = c; v.f = f; v.iv = iv; v.d = d; v.ordy = ordy;
        v.ev = ev; v.ed = ed; v.er = er; v.ecnt = ecnt;
        vq.push_back(v);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        //   c     f     iv    data    ordy  ev    edata   er    cnt
        add(1'b1, 1'b0, 1'b0, 32'h00, 1'b0, 1'b0, 32'h00, 1'b1, 0);
        add(1'b1, 1'b0, 1'b0, 32'h00, 1'b0, 1'b0, 32'h00, 1'b1, 0);
        add(1'b0, 1'b0, 1'b0, 32'h00, 1'b1, 1'b0, 32'h00, 1'b1, 0);
        add(1'b0, 1'b0, 1'b1, 32'h11, 1'b1, 1'b1, 32'h11, 1'b1, 0);
        add(1'b0, 1'b0, 1'b1, 32'h22, 1'b1, 1'b1, 32'h22, 1'b1, 0);
        add(1'b0, 1'b0, 1'b1, 32'h33, 1'b1, 1'b1, 32'h33, 1'b1, 0);
        add(1'b0, 1'b0, 1'b0, 32'h00, 1'b1, 1'b0, 32'h00, 1'b1, 0);
        add(1'b0, 1'b0, 1'b1, 32'hA1, 1'b0, 1'b1, 32'hA1, 1'b1, 0);
        add(1'b0, 1'b0, 1'b1, 32'hA2, 1'b0, 1'b1, 32'hA1, 1'b0, 1);
        add(1'b0, 1'b0, 1'b1, 32'hA3, 1'b0, 1'b1, 32'hA1, 1'b0, 2);
        add(1'b0, 1'b0, 1'b1, 32'hA3, 1'b1, 1'b1, 32'hA2, 1'b1, 2);
        add(1'b0, 1'b0, 1'b1, 32'hA3, 1'b1, 1'b1, 32'hA3, 1'b1, 2);
        add(1'b0, 1'b0, 1'b0, 32'h00, 1'b1, 1'b0, 32'h00, 1'b1, 2);
        add(1'b0, 1'b0, 1'b1, 32'hB1, 1'b0, 1'b1, 32'hB1, 1'b1, 2);
        add(1'b0, 1'b0, 1'b1, 32'hB2, 1'b0, 1'b1, 32'hB1, 1'b0, 3);
        add(1'b0, 1'b1, 1'b1, 32'hFF, 1'b0, 1'b0, 32'h00, 1'b1, 4);
        add(1'b0, 1'b0, 1'b0, 32'h00, 1'b1, 1'b0, 32'h00, 1'b1, 4);
        add(1'b0, 1'b0, 1'b1, 32'hC1, 1'b0, 1'b1, 32'hC1, 1'b1, 4);
        add(1'b0, 1'b0, 1'b1, 32'hC2, 1'b0, 1'b1, 32'hC1, 1'b0, 5);
        add(1'b1, 1'b0, 1'b0, 32'h00, 1'b1, 1'b0, 32'h00, 1'b1, 0);
        add(1'b0, 1'b0, 1'b1, 32'h5A, 1'b0, 1'b1, 32'h5A, 1'b1, 0);
        add(1'b0, 1'b0, 1'b0, 32'h00, 1'b1, 1'b0, 32'h00, 1'b1, 0);

        for (int i = 0; i < vq.size(); i++) begin
            cycle(vq[i].c, vq[i].f, vq[i].iv, vq[i].d, vq[i].ordy, 1'b1);
            chk($sformatf("row%0d valid", i), 32'(out_valid), 32'(vq[i].ev));
            chk($sformatf("row%0d data", i), out_data, vq[i].ed);
            chk($sformatf("row%0d ready", i), 32'(in_ready), 32'(vq[i].er));
            chk($sformatf("row%0d stall", i), 32'(stall_cnt), 32'(vq[i].ecnt));
        end

        // Saturation: one entry held under a long stall.
        cycle(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
        cycle(1'b0, 1'b0, 1'b1, 32'h77, 1'b0, 1'b1);
        for (int i = 0; i < 65534; i++) cycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        chk("stall near max", 32'(stall_cnt), 32'hFFFE);
        for (int i = 0; i < 4466; i++) cycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        chk("stall saturated", 32'(stall_cnt), 32'hFFFF);
        chk("held during stall", out_data, 32'h77);
        cycle(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b1);
        chk("stall kept over flush", 32'(stall_cnt), 32'hFFFF);
        cycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
        chk("stall still saturated", 32'(stall_cnt), 32'hFFFF);

        // Random traffic against the model.
        cycle(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
        for (int i = 0; i < 3000; i++) begin
            cycle(($urandom_range(0, 199) == 0), ($urandom_range(0, 59) == 0),
                  ($urandom_range(0, 3) != 0), $urandom, ($urandom_range(0, 2) != 0), 1'b1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/pipe_skid_reg.md
PIPE_SKID_REG -- requirements
Module: pipe_skid_reg

Interface
REQ-001 Parameter WIDTH, default 96: payload width in bits (PC4, PC and Inst packed by the instantiating stage).
REQ-002 Parameter NOP_VAL, default all-zero WIDTH bits: bubble value driven on out_data when no entry is valid.
REQ-003 Parameter CNT_W, default 16: width of the stall counter.
REQ-004 Clk  input  1  single clock; every register updates on the falling edge of Clk, matching the pipeline register family.
REQ-005 Clr  input  1  synchronous active-high reset, sampled on the updating edge.
REQ-006 flush  input  1  discards all held entries (control-hazard bubble).
REQ-007 in_valid  input  1  upstream entry present.
REQ-008 in_ready  output  1  block accepts an entry this cycle; driven from a register, never combinationally from out_ready.
REQ-009 in_data  input  WIDTH  upstream payload.
REQ-010 out_valid  output  1  downstream entry present.
REQ-011 out_ready  input  1  downstream consumes (low = stall).
REQ-012 out_data  output  WIDTH  head payload; equals NOP_VAL whenever out_valid is 0.
REQ-013 stall_cnt  output  CNT_W  count of cycles with out_valid=1 and out_ready=0.

Function
REQ-014 Storage: two slots, MAIN (head, drives out_data) and SKID (overflow); FIFO order is strictly preserved.
REQ-015 States: EMPTY (no slot valid), ONE (MAIN valid), FULL (MAIN and SKID valid).
REQ-016 in_ready = 1 in EMPTY and ONE, 0 in FULL; out_valid = 1 in ONE and FULL.
REQ-017 Accept = in_valid & in_ready; pop = out_valid & out_ready; both evaluated on the same edge.
REQ-018 EMPTY: accept -> ONE, MAIN <= in_data; no accept -> stays EMPTY.
REQ-019 ONE: accept & pop -> ONE, MAIN <= in_data; accept & !pop -> FULL, SKID <= in_data; !accept & pop -> EMPTY; neither -> stays ONE, MAIN held.
REQ-020 FULL: pop -> ONE, MAIN <= SKID; !pop -> FULL, both slots held; in_data is ignored.
REQ-021 Latency: an entry accepted into an EMPTY block is presented on out_valid/out_data one edge later; throughput is one entry per cycle while out_ready stays high.
REQ-022 Flush: next state EMPTY, both slots <= NOP_VAL, and any simultaneous accept is discarded; flush has priority over accept and pop, and Clr has priority over flush.
REQ-023 stall_cnt increments by 1 on each edge where out_valid=1 and out_ready=0, saturates at 2^CNT_W-1, and is unaffected by flush.
REQ-024 Invalid slots always hold NOP_VAL, so out_data never exposes stale payload.

Reset
REQ-025 Clr=1 -> state EMPTY, MAIN=SKID=NOP_VAL, out_valid=0, in_ready=1 (after the edge), stall_cnt=0.
REQ-026 Clr asserted mid-operation (ONE or FULL) discards all entries on that edge; no partial pop or accept is applied.

Structure
REQ-027 A shared package holds the state enum (EMPTY/ONE/FULL) and the default NOP constant; the IF/ID, ID/EX, EX/MEM and MEM/WB payload width constants also live in that package.
REQ-028 Sub-module pipe_slot (a WIDTH-bit register with load, clear-to-NOP and hold) is instantiated twice, for MAIN and SKID.
REQ-029 The state register and the next-state logic stay in pipe_skid_reg.

Verification (WIDTH=32, NOP_VAL=0)
REQ-030 Clr for 2 cycles, then release -> out_valid=0, out_data=0, in_ready=1, stall_cnt=0.
REQ-031 Stream 0x11,0x22,0x33 on consecutive cycles with out_ready=1 -> the same values appear in order, one cycle later each, with no gaps.
REQ-032 Push 0xA1, 0xA2 with out_ready=0 -> state FULL, in_ready=0, out_data=0xA1; then 0xA3 is offered and not accepted; out_ready=1 for 2 cycles -> output 0xA1 then 0xA2, and 0xA3 is accepted once in_ready returns to 1.
REQ-033 FULL with flush=1 and in_valid=1 (data 0xFF) -> next cycle out_valid=0, out_data=0, in_ready=1, and 0xFF is never output.
REQ-034 Hold out_valid=1 with out_ready=0 for 70000 cycles at CNT_W=16 -> stall_cnt=0xFFFF and stays there (saturation).
REQ-035 Clr asserted while FULL with out_ready=1 on the same edge -> EMPTY and no value popped; then push 0x5A -> output 0x5A.
